alu_step_sequencer: RTL

ALU_STEP_SEQUENCER -- requirements
Module: alu_step_sequencer

---
 rtl/alu_step_sequencer_pkg.sv | 69 ++++++
 rtl/alu_step_sequencer_reg_decoder.sv | 25 ++
 rtl/alu_step_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_step_sequencer_pkg.sv
// Shared constants for the ALU step sequencer: state encoding, opcodes and
// instruction field positions, plus small decode helpers.
package alu_step_sequencer_pkg;

  // State codes double as the reported step number; IDLE and HALT report 0.
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_T1   = 4'd2;
  localparam logic [3:0] ST_T2   = 4'd3;
  localparam logic [3:0] ST_T3   = 4'd4;
  localparam logic [3:0] ST_T4   = 4'd5;
  localparam logic [3:0] ST_T5   = 4'd6;
  localparam logic [3:0] ST_T6   = 4'd7;
  localparam logic [3:0] ST_HALT = 4'd8;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  localparam int REG_IDX_W = 4;

  typedef struct packed {
    logic [4:0]           op;
    logic [REG_IDX_W-1:0] ra;
    logic [REG_IDX_W-1:0] rb;
    logic [REG_IDX_W-1:0] rc;
  } instr_fields_t;

  function automatic instr_fields_t decode_fields(input logic [31:0] word);
    instr_fields_t f;
    f.op = word[OP_MSB:OP_LSB];
    f.ra = word[RA_MSB:RA_LSB];
    f.rb = word[RB_MSB:RB_LSB];
    f.rc = word[RC_MSB:RC_LSB];
    return f;
  endfunction

  function automatic logic is_alu_op(input logic [4:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // mul/div produce a 64-bit result and need the extra T6 step.
  function automatic logic is_long_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic [3:0] step_of(input logic [3:0] state);
    return (state == ST_HALT) ? 4'd0 : state;
  endfunction

endpackage

// File: rtl/alu_step_sequencer_reg_decoder.sv
// Register index to one-hot enable decoder; indices beyond NUM_REGS decode to
// no enable at all.
module reg_decoder
  import alu_step_sequencer_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [REG_IDX_W-1:0] index,
  input  logic                 enable,
  output logic [NUM_REGS-1:0]  onehot
);

  // One-hot decode, gated by enable.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (enable && (index == REG_IDX_W'(i))) begin
        onehot[i] = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_step_sequencer.sv
// Moore control sequencer stepping a register-file/ALU datapath through
// fetch (T0-T2) and execute (T3-T6) for a small three-register instruction set.
module alu_step_sequencer
  import alu_step_sequencer_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   ir,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [OP_W-1:0]     alu_op,
  output logic [3:0]          step,
  output logic                done,
  output logic                illegal
);

  logic [3:0]           state_r;
  logic [3:0]           state_next_s;
  logic                 t1_first_r;
  logic [DATA_W-1:0]    ir_r;
  instr_fields_t        fields_s;
  logic                 halt_s;
  logic                 legal_s;
  logic                 long_s;
  logic                 rin_en_s;
  logic                 rout_en_s;
  logic [REG_IDX_W-1:0] rin_idx_s;
  logic [REG_IDX_W-1:0] rout_idx_s;
  logic                 unused_ir_s;

  function automatic logic in_range(input logic [REG_IDX_W-1:0] idx);
    return ({1'b0, idx} < 5'(NUM_REGS));
  endfunction

  assign fields_s    = decode_fields(ir_r[31:0]);
  assign halt_s      = (fields_s.op == OP_HALT);
  assign long_s      = is_long_op(fields_s.op);
  assign legal_s     = is_alu_op(fields_s.op) && in_range(fields_s.ra) &&
                       in_range(fields_s.rb) && in_range(fields_s.rc);
  assign step        = step_of(state_r);
  assign unused_ir_s = ^ir_r;

  // Next-state logic; run is consulted only in IDLE and at instruction end.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) state_next_s = ST_T0;
        else     state_next_s = ST_IDLE;
      end
      ST_T0: state_next_s = ST_T1;
      ST_T1: begin
        if (mem_ready) state_next_s = ST_T2;
        else           state_next_s = ST_T1;
      end
      ST_T2: state_next_s = ST_T3;
      ST_T3: begin
        if (halt_s)       state_next_s = ST_HALT;
        else if (legal_s) state_next_s = ST_T4;
        else if (run)     state_next_s = ST_T0;
        else              state_next_s = ST_IDLE;
      end
      ST_T4: state_next_s = ST_T5;
      ST_T5: begin
        if (long_s)   state_next_s = ST_T6;
        else if (run) state_next_s = ST_T0;
        else          state_next_s = ST_IDLE;
      end
      ST_T6: begin
        if (run) state_next_s = ST_T0;
        else     state_next_s = ST_IDLE;
      end
      ST_HALT: state_next_s = ST_HALT;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, first-T1-cycle flag and instruction latch.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r    <= ST_IDLE;
      t1_first_r <= 1'b0;
      ir_r       <= '0;
    end else begin
      state_r    <= state_next_s;
      t1_first_r <= (state_r == ST_T0);
      if (state_r == ST_T2) ir_r <= ir;
      else                  ir_r <= ir_r;
    end
  end

  // Moore output decode from state and the latched instruction.
  always_comb begin
    PCout      = 1'b0;
    PCin       = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    alu_op     = '0;
    done       = 1'b0;
    illegal    = 1'b0;
    rin_en_s   = 1'b0;
    rout_en_s  = 1'b0;
    rin_idx_s  = fields_s.ra;
    rout_idx_s = fields_s.rb;
    case (state_r)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = t1_first_r;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        if (halt_s) begin
          illegal = 1'b0;
        end else if (legal_s) begin
          rout_en_s = 1'b1;
          Yin       = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      ST_T4: begin
        rout_en_s  = 1'b1;
        rout_idx_s = fields_s.rc;
        Zin        = 1'b1;
        alu_op     = OP_W'(fields_s.op);
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (long_s) begin
          LOin = 1'b1;
        end else begin
          rin_en_s = 1'b1;
          done     = 1'b1;
        end
      end
      ST_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  reg_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .index  (rin_idx_s),
    .enable (rin_en_s),
    .onehot (Rin)
  );

  reg_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .index  (rout_idx_s),
    .enable (rout_en_s),
    .onehot (Rout)
  );

endmodule
